// File: rtl/s298_resp_misr.sv
// BIST response compactor for the s298 core: warm-up skip, MISR compaction, golden compare.
// Optional serial unload of the signature is enabled by defining MISR_UNLOAD_EN.
module s298_resp_misr #(
    parameter int unsigned       RESP_W = 6,
    parameter int unsigned       SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED   = 16'h0000,
    parameter int unsigned       WARMUP = 8,
    parameter int unsigned       CYCLES = 256,
    parameter logic [SIG_W-1:0]  GOLDEN = 16'h0000
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic [RESP_W-1:0] RESP,
    input  logic              RESP_VALID,
`ifdef MISR_UNLOAD_EN
    input  logic              UNLOAD,
    output logic              SO,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic [SIG_W-1:0]  SIG,
    output logic              PASS,
    output logic              FAIL
);

    localparam int unsigned CNT_MAX = (WARMUP > CYCLES) ? WARMUP : CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCompact, StDone} state_e;

    localparam state_e FIRST_RUN = (WARMUP == 0) ? StCompact : StSettle;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [SIG_W-1:0]   sig_fold;

    // Galois MISR step with the response folded into the low bits.
    always_comb begin
        sig_fold = {sig_q[SIG_W-2:0], 1'b0};
        if (sig_q[SIG_W-1]) begin
            sig_fold = sig_fold ^ POLY;
        end
        sig_fold = sig_fold ^ SIG_W'(RESP);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = FIRST_RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = StCompact;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCompact: begin
                if (RESP_VALID) begin
                    sig_d = sig_fold;
                    if (cnt_q == CYC_LAST) begin
                        state_d = StDone;
                        cnt_d   = '0;
                        pass_d  = (sig_fold == GOLDEN);
                        fail_d  = (sig_fold != GOLDEN);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                if (START) begin
                    state_d = FIRST_RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
`ifdef MISR_UNLOAD_EN
                // Verdict stays latched while the tester shifts the signature out.
                else if (UNLOAD) begin
                    sig_d = {sig_q[SIG_W-2:0], 1'b0};
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sig_q   <= SEED;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign BUSY = (state_q == StSettle) || (state_q == StCompact);
    assign DONE = (state_q == StDone);
    assign SIG  = sig_q;
    assign PASS = pass_q;
    assign FAIL = fail_q;
`ifdef MISR_UNLOAD_EN
    assign SO   = sig_q[SIG_W-1];
`endif

endmodule

// File: tb/tb_s298_resp_misr.sv
// Directed bench for s298_resp_misr over several parameter sets; final signatures go
// through a scoreboard queue. Covers MISR_UNLOAD_EN when that macro is defined.
module tb_s298_resp_misr;

    logic        ck = 1'b0;
    logic        ck_run = 1'b1;
    logic        rst;
    logic [4:0]  start;
    logic [5:0]  resp;
    logic        valid;
    logic [4:0]  busy, done, pass, fail;
    logic [15:0] sig [5];
`ifdef MISR_UNLOAD_EN
    logic        unload;
    logic        so;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    always #5 if (ck_run) ck = ~ck;

    // a: WARMUP=0 CYCLES=1; b: WARMUP=2 CYCLES=2 GOLDEN=7E; c: feedback; d: defaults; e: unload
    s298_resp_misr #(.WARMUP(0), .CYCLES(1), .SEED(16'h0000)) u_a (
        .CK(ck), .RST(rst), .START(start[0]), .RESP(resp), .RESP_VALID(valid),
`ifdef MISR_UNLOAD_EN
        .UNLOAD(1'b0), .SO(),
`endif
        .BUSY(busy[0]), .DONE(done[0]), .SIG(sig[0]), .PASS(pass[0]), .FAIL(fail[0]));

    s298_resp_misr #(.WARMUP(2), .CYCLES(2), .GOLDEN(16'h007E)) u_b (
        .CK(ck), .RST(rst), .START(start[1]), .RESP(resp), .RESP_VALID(valid),
`ifdef MISR_UNLOAD_EN
        .UNLOAD(1'b0), .SO(),
`endif
        .BUSY(busy[1]), .DONE(done[1]), .SIG(sig[1]), .PASS(pass[1]), .FAIL(fail[1]));

    s298_resp_misr #(.WARMUP(0), .CYCLES(1), .SEED(16'h8000), .GOLDEN(16'h1021)) u_c (
        .CK(ck), .RST(rst), .START(start[2]), .RESP(resp), .RESP_VALID(valid),
`ifdef MISR_UNLOAD_EN
        .UNLOAD(1'b0), .SO(),
`endif
        .BUSY(busy[2]), .DONE(done[2]), .SIG(sig[2]), .PASS(pass[2]), .FAIL(fail[2]));

    s298_resp_misr u_d (
        .CK(ck), .RST(rst), .START(start[3]), .RESP(resp), .RESP_VALID(valid),
`ifdef MISR_UNLOAD_EN
        .UNLOAD(1'b0), .SO(),
`endif
        .BUSY(busy[3]), .DONE(done[3]), .SIG(sig[3]), .PASS(pass[3]), .FAIL(fail[3]));

    s298_resp_misr #(.WARMUP(0), .CYCLES(1), .SEED(16'hDAF1), .GOLDEN(16'hA5C3)) u_e (
        .CK(ck), .RST(rst), .START(start[4]), .RESP(resp), .RESP_VALID(valid),
`ifdef MISR_UNLOAD_EN
        .UNLOAD(unload), .SO(so),
`endif
        .BUSY(busy[4]), .DONE(done[4]), .SIG(sig[4]), .PASS(pass[4]), .FAIL(fail[4]));

    function automatic logic [15:0] nxt(input logic [15:0] s, input logic [5:0] r);
        logic [15:0] t;
        t = s << 1;
        if (s[15]) t = t ^ 16'h1021;
        return t ^ {10'b0, r};
    endfunction

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_sig(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {16'h0, obs}, {16'h0, e});
        end
    endtask

    initial begin
        logic [15:0] e;
        int          m_settle;
        int          m_cnt;
        logic [15:0] m_sig;
        rst   = 1'b1;
        start = '0;
        resp  = '0;
        valid = 1'b0;
`ifdef MISR_UNLOAD_EN
        unload = 1'b0;
`endif
        step();
        for (int k = 0; k < 5; k++) begin
            chk("rst_busy", busy[k], 0);
            chk("rst_done", done[k], 0);
            chk("rst_pass", pass[k], 0);
            chk("rst_fail", fail[k], 0);
        end
        chk("rst_sig_c", sig[2], 16'h8000);
        chk("rst_sig_e", sig[4], 16'hDAF1);
        rst = 1'b0;

        // Mid-run async reset with the clock stopped
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        valid = 1'b1;
        resp  = 6'h3F;
        repeat (12) step();
        e = 16'h0;
        repeat (4) e = nxt(e, 6'h3F);
        chk("midrun_sig", sig[3], e);
        chk("midrun_busy", busy[3], 1);
        ck_run = 1'b0;
        #20;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy[3], 0);
        chk("async_rst_done", done[3], 0);
        chk("async_rst_pass", pass[3], 0);
        chk("async_rst_fail", fail[3], 0);
        chk("async_rst_sig", sig[3], 16'h0000);
        rst = 1'b0;
        #1;
        ck_run = 1'b1;
        valid = 1'b0;
        step();

        // A: single sample, no warm-up
        start[0] = 1'b1;
        resp     = 6'h01;
        valid    = 1'b1;
        exp_q.push_back(nxt(16'h0000, 6'h01));
        step();
        start[0] = 1'b0;
        chk("a_busy", busy[0], 1);
        chk("a_done_early", done[0], 0);
        step();
        chk("a_done", done[0], 1);
        chk_sig("a_sig", sig[0]);
        chk("a_pass", pass[0], 0);
        chk("a_fail", fail[0], 1);

        // B: two-cycle warm-up then 3F, 00
        start[1] = 1'b1;
        resp     = 6'h3F;
        exp_q.push_back(nxt(nxt(16'h0000, 6'h3F), 6'h00));
        step();
        start[1] = 1'b0;
        step();
        chk("b_settle_sig_held", sig[1], 16'h0000);
        step();
        chk("b_settle_busy", busy[1], 1);
        step();
        chk("b_sig1", sig[1], 16'h003F);
        chk("b_done_early", done[1], 0);
        resp = 6'h00;
        step();
        chk("b_done", done[1], 1);
        chk_sig("b_sig2", sig[1]);
        chk("b_pass", pass[1], 1);
        chk("b_fail", fail[1], 0);

        // C: feedback taps from MSB
        start[2] = 1'b1;
        exp_q.push_back(nxt(16'h8000, 6'h00));
        step();
        start[2] = 1'b0;
        step();
        chk("c_done", done[2], 1);
        chk_sig("c_sig", sig[2]);
        chk("c_pass", pass[2], 1);

        // E: final 16'hA5C3, then optional serial unload
        start[4] = 1'b1;
        exp_q.push_back(nxt(16'hDAF1, 6'h00));
        step();
        start[4] = 1'b0;
        step();
        chk("e_done", done[4], 1);
        chk_sig("e_sig", sig[4]);
        chk("e_pass", pass[4], 1);
`ifdef MISR_UNLOAD_EN
        e = 16'hA5C3;
        unload = 1'b1;
        for (int b = 15; b >= 0; b--) begin
            chk("e_so_bit", so, e[b]);
            step();
        end
        unload = 1'b0;
        chk("e_unload_sig", sig[4], 16'h0000);
        chk("e_unload_pass", pass[4], 1);
        chk("e_unload_fail", fail[4], 0);
        chk("e_unload_done", done[4], 1);
`endif

        // D: defaults, RESP_VALID toggling, START re-pulsed while busy
        e = 16'h0;
        repeat (256) e = nxt(e, 6'h00);
        exp_q.push_back(e);
        start[3] = 1'b1;
        resp     = 6'h00;
        valid    = 1'b0;
        step();
        start[3] = 1'b0;
        m_settle = 8;
        m_cnt    = 0;
        m_sig    = 16'h0;
        for (int i = 0; i < 1000 && m_cnt < 256; i++) begin
            valid    = (i % 2 == 0);
            start[3] = (i == 100);
            step();
            if (m_settle > 0) begin
                m_settle--;
            end else if (valid) begin
                m_sig = nxt(m_sig, 6'h00);
                m_cnt++;
            end
            chk("d_done_timing", done[3], (m_cnt == 256));
            if (i == 100) chk("d_busy_at_restart", busy[3], 1);
        end
        start[3] = 1'b0;
        valid    = 1'b0;
        chk_sig("d_sig", sig[3]);
        chk("d_pass", pass[3], 1);
        chk("d_fail", fail[3], 0);
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        chk("d_restart_busy", busy[3], 1);
        chk("d_restart_done", done[3], 0);
        chk("d_restart_pass", pass[3], 0);
        chk("d_restart_sig", sig[3], 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
